// File: rtl/xpb_reduce_acc.sv
// Packet accumulator for xpb reduction terms: a segmented adder with
// registered inter-segment carries, flushed before the sum is presented.
module xpb_reduce_acc #(
    parameter int WORD_W    = 1024,
    parameter int SEG_W     = 256,
    parameter int MAX_TERMS = 32,
    localparam int NSEG     = WORD_W / SEG_W,
    localparam int EXT_W    = $clog2(MAX_TERMS) + 1,
    localparam int ACC_W    = WORD_W + EXT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic [EXT_W-1:0]  out_count,
    output logic              out_err,
    output logic              busy
);

    localparam int FC_W = $clog2(NSEG);
    localparam logic [EXT_W-1:0] MAX_C = EXT_W'(MAX_TERMS);
    localparam logic [FC_W-1:0] LAST_F = FC_W'(NSEG - 2);

    typedef enum logic [1:0] {IDLE, ACC, FLUSH, DONE} state_t;

    state_t            state_q, state_d;
    logic [SEG_W-1:0]  seg_q [NSEG];
    logic [SEG_W-1:0]  seg_d [NSEG];
    logic [NSEG-2:0]   cy_q, cy_d;
    logic [EXT_W-1:0]  ext_q, ext_d;
    logic [EXT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [FC_W-1:0]   fcnt_q, fcnt_d;

    logic              clr;
    logic              take;
    logic              fin;
    logic [EXT_W-1:0]  nxt_cnt;
    logic [NSEG-1:0]   cin_v;
    logic [NSEG-1:0]   cout_v;
    logic [SEG_W:0]    psum [NSEG];

    assign clr      = (state_q == IDLE);
    assign in_ready = rst_n && (state_q == IDLE || state_q == ACC);
    assign take     = in_valid && in_ready;
    assign nxt_cnt  = clr ? EXT_W'(1) : cnt_q + EXT_W'(1);
    assign fin      = in_last || (nxt_cnt == MAX_C);
    // IDLE discards whatever the previous packet left behind
    assign cin_v    = clr ? '0 : {cy_q, 1'b0};

    always_comb begin
        cout_v = '0;
        for (int i = 0; i < NSEG; i++) begin
            psum[i] = {1'b0, (clr ? '0 : seg_q[i])}
                    + {1'b0, (take ? in_data[i*SEG_W +: SEG_W] : '0)}
                    + (SEG_W+1)'(cin_v[i]);
            seg_d[i]  = psum[i][SEG_W-1:0];
            cout_v[i] = psum[i][SEG_W];
        end
        cy_d  = cout_v[NSEG-2:0];
        ext_d = (clr ? '0 : ext_q) + EXT_W'(cout_v[NSEG-1]);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fcnt_d  = fcnt_q;
        unique case (state_q)
            IDLE, ACC: begin
                if (take) begin
                    cnt_d = nxt_cnt;
                    if (fin) begin
                        state_d = FLUSH;
                        fcnt_d  = '0;
                        err_d   = !in_last;
                    end else begin
                        state_d = ACC;
                        if (clr) err_d = 1'b0;
                    end
                end
            end
            FLUSH: begin
                if (fcnt_q == LAST_F) state_d = DONE;
                else fcnt_d = fcnt_q + FC_W'(1);
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            seg_q   <= '{default: '0};
            cy_q    <= '0;
            ext_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            seg_q   <= seg_d;
            cy_q    <= cy_d;
            ext_q   <= ext_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_comb begin
        out_data = '0;
        for (int i = 0; i < NSEG; i++)
            out_data[i*SEG_W +: SEG_W] = seg_q[i];
        out_data[ACC_W-1 -: EXT_W] = ext_q;
    end

    assign out_valid = (state_q == DONE);
    assign out_count = cnt_q;
    assign out_err   = err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_xpb_reduce_acc.sv
// Bench for xpb_reduce_acc: packet-level sum model plus directed packets
// with literal expected results.
module tb_xpb_reduce_acc;

    localparam int WORD_W    = 1024;
    localparam int SEG_W     = 256;
    localparam int MAX_TERMS = 32;
    localparam int NSEG      = WORD_W / SEG_W;
    localparam int EXT_W     = $clog2(MAX_TERMS) + 1;
    localparam int ACC_W     = WORD_W + EXT_W;
    localparam int LAT       = NSEG - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_data;
    logic [EXT_W-1:0]  out_count;
    logic              out_err;
    logic              busy;

    int checks = 0;
    int errors = 0;

    xpb_reduce_acc #(
        .WORD_W(WORD_W), .SEG_W(SEG_W), .MAX_TERMS(MAX_TERMS)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_count(out_count),
        .out_err(out_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [ACC_W-1:0] act,
                       logic [ACC_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h (low 160 bits)",
                     nm, act[159:0], exp[159:0]);
        end
    endtask

    // Packet model: sum of accepted terms; result pending until handshake
    logic [ACC_W-1:0] m_sum, r_sum;
    int               m_cnt, r_cnt, m_lat;
    logic             m_pend, r_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sum  <= '0;
            m_cnt  <= 0;
            m_pend <= 1'b0;
            m_lat  <= 0;
            r_sum  <= '0;
            r_cnt  <= 0;
            r_err  <= 1'b0;
        end else if (m_pend) begin
            if (m_lat == LAT) begin
                if (out_ready) m_pend <= 1'b0;
            end else begin
                m_lat <= m_lat + 1;
            end
        end else if (in_valid) begin
            if (in_last || m_cnt + 1 == MAX_TERMS) begin
                r_sum  <= m_sum + ACC_W'(in_data);
                r_cnt  <= m_cnt + 1;
                r_err  <= !in_last;
                m_pend <= 1'b1;
                m_lat  <= 0;
                m_sum  <= '0;
                m_cnt  <= 0;
            end else begin
                m_sum <= m_sum + ACC_W'(in_data);
                m_cnt <= m_cnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", ACC_W'(in_ready), ACC_W'(!m_pend));
            chk("out_valid", ACC_W'(out_valid),
                ACC_W'(m_pend && m_lat == LAT));
            chk("busy", ACC_W'(busy), ACC_W'(m_pend || m_cnt != 0));
            if (m_pend && m_lat == LAT) begin
                chk("model_data", out_data, r_sum);
                chk("model_count", ACC_W'(out_count), ACC_W'(r_cnt));
                chk("model_err", ACC_W'(out_err), ACC_W'(r_err));
            end
        end
    end

    task automatic beat(logic [WORD_W-1:0] d, logic l);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
    endtask

    task automatic gap(int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("valid_timeout", ACC_W'(out_valid), ACC_W'(1));
    endtask

    task automatic lit(string nm, logic [ACC_W-1:0] d, int c, logic e);
        chk({nm, "_data"}, out_data, d);
        chk({nm, "_count"}, ACC_W'(out_count), ACC_W'(c));
        chk({nm, "_err"}, ACC_W'(out_err), ACC_W'(e));
    endtask

    logic [ACC_W-1:0] ones;

    initial begin
        ones = '0;
        ones[WORD_W-1:0] = '1;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        #3;
        chk("rst_ready", ACC_W'(in_ready), ACC_W'(0));
        chk("rst_valid", ACC_W'(out_valid), ACC_W'(0));
        chk("rst_data", out_data, ACC_W'(0));
        chk("rst_busy", ACC_W'(busy), ACC_W'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // single beat
        beat(WORD_W'(5), 1'b1);
        gap(1);
        wait_valid();
        lit("single", ACC_W'(5), 1, 1'b0);
        gap(2);

        // full carry ripple across all segments
        beat(ones[WORD_W-1:0], 1'b0);
        beat(ones[WORD_W-1:0], 1'b1);
        gap(1);
        wait_valid();
        lit("ripple", ones << 1, 2, 1'b0);
        gap(2);

        // truncation at MAX_TERMS
        for (int i = 0; i < MAX_TERMS; i++) beat(ones[WORD_W-1:0], 1'b0);
        gap(1);
        chk("trunc_ready", ACC_W'(in_ready), ACC_W'(0));
        wait_valid();
        lit("trunc", ones << 5, 32, 1'b1);
        gap(2);

        // input gaps and output backpressure
        out_ready = 1'b0;
        beat(WORD_W'(1), 1'b0);
        gap(2);
        beat(WORD_W'(2), 1'b0);
        gap(2);
        beat(WORD_W'(3), 1'b1);
        gap(1);
        wait_valid();
        repeat (5) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = WORD_W'(77);
            chk("hold_data", out_data, ACC_W'(6));
            chk("hold_ready", ACC_W'(in_ready), ACC_W'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("hs_valid", ACC_W'(out_valid), ACC_W'(0));
        chk("hs_busy", ACC_W'(busy), ACC_W'(0));

        // reset mid-packet
        beat(WORD_W'(7), 1'b0);
        beat(WORD_W'(7), 1'b0);
        gap(1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_data", out_data, ACC_W'(0));
        chk("abort_busy", ACC_W'(busy), ACC_W'(0));
        chk("abort_ready", ACC_W'(in_ready), ACC_W'(0));
        #1 rst_n = 1'b1;
        beat(WORD_W'(9), 1'b1);
        gap(1);
        wait_valid();
        lit("after_rst", ACC_W'(9), 1, 1'b0);
        gap(2);

        // back-to-back packets
        beat(WORD_W'(4), 1'b0);
        beat(WORD_W'(6), 1'b1);
        gap(1);
        wait_valid();
        lit("b2b_a", ACC_W'(10), 2, 1'b0);
        beat(WORD_W'(10), 1'b0);
        beat(WORD_W'(20), 1'b1);
        gap(1);
        wait_valid();
        lit("b2b_b", ACC_W'(30), 2, 1'b0);
        gap(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xpb_reduce_acc.md
XPB_REDUCE_ACC -- requirements
Module: xpb_reduce_acc

Interface
REQ-001 SHALL provide parameter WORD_W, default 1024, width of one precomputed reduction term from a 5-bit xpb lookup table.
REQ-002 SHALL provide parameter SEG_W, default 256, adder segment width; WORD_W SHALL be an integer multiple of SEG_W; NSEG = WORD_W/SEG_W.
REQ-003 SHALL provide parameter MAX_TERMS, default 32, maximum terms per packet; EXT_W = clog2(MAX_TERMS)+1; ACC_W = WORD_W+EXT_W.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  term beat valid.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 in_data  input  WORD_W  xpb term (a lookup-table data_out).
REQ-009 in_last  input  1  final term of the packet.
REQ-010 out_valid  output  1  sum available.
REQ-011 out_ready  input  1  consumer takes the sum.
REQ-012 out_data  output  ACC_W  full unreduced sum of the packet's terms.
REQ-013 out_count  output  EXT_W  number of beats in the packet.
REQ-014 out_err  output  1  packet truncated at MAX_TERMS.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 States SHALL be IDLE, ACC, FLUSH and DONE.
REQ-017 in_ready SHALL be 1 in IDLE and ACC and 0 in FLUSH and DONE; a beat is accepted when in_valid and in_ready are both 1.
REQ-018 Accumulator SHALL be NSEG segment registers plus NSEG-1 single-bit carry registers; EXT_W extension bits SHALL sit on top of the top segment.
REQ-019 Per edge, segment i SHALL load seg_i + addend_i + carry_(i-1), using the registered carry; the carry-out of segment i SHALL be registered as carry_i; the top segment's carry-out SHALL add directly into the extension bits.
REQ-020 Addend SHALL be in_data on an accepted beat and zero otherwise.
REQ-021 Accepted beat in IDLE: accumulator and carries SHALL first be treated as zero, so the result is in_data alone; count SHALL be 1; out_err SHALL be cleared.
REQ-022 Accepted beat in IDLE or ACC with in_last=0: next state SHALL be ACC; count SHALL increment.
REQ-023 Accepted beat with in_last=1, or the beat that makes count equal MAX_TERMS: next state SHALL be FLUSH.
REQ-024 A beat forced last by MAX_TERMS while in_last=0 SHALL set out_err=1.
REQ-025 FLUSH SHALL last exactly NSEG-1 cycles with a zero addend, then go to DONE; all carry registers SHALL be zero on entry to DONE.
REQ-026 out_valid SHALL rise exactly NSEG-1 edges after the edge accepting the last beat (3 for defaults) and SHALL be registered.
REQ-027 In DONE, out_valid=1 and out_data/out_count/out_err SHALL be held stable until out_ready=1; on out_valid and out_ready both 1, next state SHALL be IDLE and out_valid SHALL drop on that edge.
REQ-028 While out_valid=1, no beat SHALL be accepted, so a new packet starts no earlier than the cycle after the handshake.
REQ-029 out_data SHALL equal the exact integer sum modulo 2^ACC_W; no overflow is possible within MAX_TERMS beats.
REQ-030 in_valid low in ACC SHALL stall without changing the accumulator value; carries MAY ripple during the stall but the represented sum SHALL be unchanged.

Reset
REQ-031 rst_n=0 SHALL, asynchronously: force state to IDLE; clear all segments, carries and count; force out_valid, out_err, busy and out_data to 0; force in_ready to 0 while asserted.
REQ-032 After rst_n deasserts, in_ready SHALL be 1 from the first edge; a packet aborted by reset mid-operation SHALL leave no trace in the next result.

Verification
REQ-033 Single beat in_data=5, in_last=1, out_ready=1 -> out_valid after 3 edges; out_data=5; out_count=1; out_err=0; then IDLE.
REQ-034 Two beats of 2^1024-1, the second with last -> out_data=2^1025-2 (full carry ripple across all segments); out_count=2.
REQ-035 32 beats of 2^1024-1 with in_last always 0 -> 32nd beat forced last; out_data=32*(2^1024-1); out_count=32; out_err=1; in_ready=0 from the edge after the 32nd beat.
REQ-036 Beats 1, 2, 3 with in_valid gaps of 2 cycles, out_ready held 0 for 5 cycles after out_valid -> out_data=6 stable throughout; in_ready=0; the handshake returns to IDLE.
REQ-037 Two beats of 7 accepted, then rst_n pulsed low mid-cycle -> outputs 0 immediately; next packet of a single beat 9 -> out_data=9, out_count=1.
REQ-038 Back-to-back packets, second beat presented the cycle after the out handshake -> both results correct, with no state carried over.
